// File: rtl/lui_instr_encoder.sv
// Request FIFO plus encoder FSM that turns {rd, value} requests into RV32I LUI (and optional ADDI) words.
// Optional feature: define LUI_ENC_ADDI_EN to emit LUI+ADDI pairs for full 32-bit constants.
module lui_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_value,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        busy,
    output logic [15:0] instr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [6:0]  OPC_LUI   = 7'b0110111;
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;

`ifdef LUI_ENC_ADDI_EN
    typedef enum logic [1:0] {S_IDLE, S_LUI, S_ADDI} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_LUI} state_t;
`endif

    function automatic logic [31:0] lui_word(input logic [4:0] rd, input logic [19:0] hi);
        return {hi, rd, OPC_LUI};
    endfunction

`ifdef LUI_ENC_ADDI_EN
    function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] lo);
        return {lo, rd, 3'b000, rd, OPC_OPIMM};
    endfunction
`endif

    state_t       state;

    logic [4:0]   rd_mem [DEPTH];
    logic [19:0]  hi_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  count;
    logic [AW:0]  count_nxt;

    logic [19:0]  push_hi;
    logic [4:0]   head_rd;
    logic [19:0]  head_hi;
    logic         push;
    logic         pop;
    logic         hs;
    logic         head_ok;
    logic         load_lui;
    logic         load_addi;
    logic         active_nxt;

`ifdef LUI_ENC_ADDI_EN
    logic [11:0]  lo_mem [DEPTH];
    logic [11:0]  head_lo;
    logic [11:0]  lo_pend;
    logic [4:0]   rd_pend;
`else
    logic         unused_lo_bits;
    assign unused_lo_bits = ^req_value[11:0];
`endif

    // The split happens on entry so the FIFO only carries what the encoder needs.
    always_comb begin
`ifdef LUI_ENC_ADDI_EN
        push_hi = req_value[31:12] + {19'd0, req_value[11]};
`else
        push_hi = req_value[31:12];
`endif
    end

    assign head_rd = rd_mem[rd_ptr];
    assign head_hi = hi_mem[rd_ptr];
`ifdef LUI_ENC_ADDI_EN
    assign head_lo = lo_mem[rd_ptr];
`endif

    assign push    = req_valid && req_ready;
    assign hs      = instr_valid && instr_ready;
    assign head_ok = (count != '0) && (head_rd != '0);

    always_comb begin
        pop       = 1'b0;
        load_lui  = 1'b0;
        load_addi = 1'b0;
        case (state)
            S_IDLE: begin
                pop      = (count != '0);
                load_lui = head_ok;
            end
            S_LUI: begin
                if (hs) begin
`ifdef LUI_ENC_ADDI_EN
                    if (lo_pend != '0) begin
                        load_addi = 1'b1;
                    end else if (head_ok) begin
                        pop      = 1'b1;
                        load_lui = 1'b1;
                    end
`else
                    if (head_ok) begin
                        pop      = 1'b1;
                        load_lui = 1'b1;
                    end
`endif
                end
            end
`ifdef LUI_ENC_ADDI_EN
            S_ADDI: begin
                if (hs && head_ok) begin
                    pop      = 1'b1;
                    load_lui = 1'b1;
                end
            end
`endif
            default: begin
                pop = 1'b0;
            end
        endcase
        // A non-idle state survives unless its word is taken with nothing to follow it.
        active_nxt = load_lui || load_addi || ((state != S_IDLE) && !hs);
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr] <= req_rd;
            hi_mem[wr_ptr] <= push_hi;
`ifdef LUI_ENC_ADDI_EN
            lo_mem[wr_ptr] <= req_value[11:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_count <= '0;
`ifdef LUI_ENC_ADDI_EN
            lo_pend     <= '0;
            rd_pend     <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            req_ready <= (count_nxt != DEPTH_C);
            busy      <= (count_nxt != '0) || active_nxt;
            if (hs) begin
                instr_count <= instr_count + 1'b1;
            end

            if (load_lui) begin
                instr       <= lui_word(head_rd, head_hi);
                instr_valid <= 1'b1;
                state       <= S_LUI;
`ifdef LUI_ENC_ADDI_EN
                lo_pend     <= head_lo;
                rd_pend     <= head_rd;
`endif
            end
`ifdef LUI_ENC_ADDI_EN
            else if (load_addi) begin
                instr   <= addi_word(rd_pend, lo_pend);
                lo_pend <= '0;
                state   <= S_ADDI;
            end
`endif
            else if (hs) begin
                instr_valid <= 1'b0;
                state       <= S_IDLE;
            end
        end
    end

endmodule
